// File: rtl/addrreg_burst.sv
// addrreg_burst -- parametrised address register with burst auto-increment.
//
// Usable as a PC, memory pointer or DMA-style address generator beside the
// ALU bus. It can load from the bus, increment, decrement, add a signed
// offset, or step through a burst of auto-increments. It also provides a
// tri-state bus driver and registered WRAP, BUSY and DONE flags.
//
// Ports
//   CLK            clock; all state changes on the rising edge
//   RST_bar        asynchronous reset, active low
//   LOAD_bar       load BUS_in on the next edge; also aborts a burst
//   ADD_bar        add sign-extended OFFSET on the next edge
//   INC / DEC      +1 / -1 on the next edge (both high: hold)
//   OFFSET         signed two's-complement offset
//   BURST_START    start a burst; sampled only in IDLE
//   BURST_LEN      number of burst increments
//   ASSERT_bar     drive value onto BUS_out when low
//   BUS_in         load data
//   BUS_out        value when ASSERT_bar=0, otherwise all Z
//   BUSY           high while a burst is running
//   DONE           one-cycle pulse when a burst completes
//   WRAP           one-cycle pulse after an update carried/borrowed out of the MSB
//   display_value  current value, always driven
//
// DELAY_RISE / DELAY_FALL are accepted so the interface matches the older
// delay-annotated model. This description itself has zero delay.
//
// Burst FSM
//   state  | meaning
//   S_IDLE | no burst; BURST_START accepted here
//   S_RUN  | burst active; steps on cycles with no explicit operation
//   S_FIN  | burst finished; DONE high for this one cycle

module addrreg_burst #(
  parameter int WIDTH      = 16,
  parameter int OFF_WIDTH  = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 CLK,
  input  logic                 RST_bar,
  input  logic                 LOAD_bar,
  input  logic                 ADD_bar,
  input  logic                 INC,
  input  logic                 DEC,
  input  logic [OFF_WIDTH-1:0] OFFSET,
  input  logic                 BURST_START,
  input  logic [LEN_WIDTH-1:0] BURST_LEN,
  input  logic                 ASSERT_bar,
  input  logic [WIDTH-1:0]     BUS_in,
  output logic [WIDTH-1:0]     BUS_out,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 WRAP,
  output logic [WIDTH-1:0]     display_value
);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32 || OFF_WIDTH > WIDTH ||
      OFF_WIDTH < 1 || LEN_WIDTH < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
    $error("addrreg_burst: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     value;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 busy_q;
  logic                 done_q;
  logic                 wrap_q;

  logic [WIDTH-1:0]     off_ext;
  logic [WIDTH:0]       sum_add;
  logic [WIDTH:0]       sum_inc;
  logic [WIDTH:0]       sum_dec;
  logic                 step;
  logic [WIDTH-1:0]     value_next;
  logic                 wrap_next;

  assign off_ext = WIDTH'($signed(OFFSET));
  assign sum_add = {1'b0, value} + {1'b0, off_ext};
  assign sum_inc = {1'b0, value} + (WIDTH+1)'(1);
  assign sum_dec = {1'b0, value} - (WIDTH+1)'(1);

  // A burst step only happens on a cycle with no explicit operation.
  // INC=DEC=1 counts as an operation (a hold), so it stalls the burst too.
  assign step = (state == S_RUN) && LOAD_bar && ADD_bar && !INC && !DEC;

  always_comb begin
    value_next = value;
    wrap_next  = 1'b0;
    if (!LOAD_bar) begin
      value_next = BUS_in;
    end else if (!ADD_bar) begin
      value_next = sum_add[WIDTH-1:0];
      // A negative offset is added as 2^WIDTH - |off|. A borrow therefore
      // shows up as the absence of a carry.
      wrap_next  = OFFSET[OFF_WIDTH-1] ? ~sum_add[WIDTH] : sum_add[WIDTH];
    end else if (INC && !DEC) begin
      value_next = sum_inc[WIDTH-1:0];
      wrap_next  = sum_inc[WIDTH];
    end else if (DEC && !INC) begin
      value_next = sum_dec[WIDTH-1:0];
      wrap_next  = sum_dec[WIDTH];
    end else if (step) begin
      value_next = sum_inc[WIDTH-1:0];
      wrap_next  = sum_inc[WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      value     <= '0;
      state     <= S_IDLE;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      value  <= value_next;
      wrap_q <= wrap_next;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (LOAD_bar && BURST_START) begin
            if (BURST_LEN != '0) begin
              state     <= S_RUN;
              remaining <= BURST_LEN;
              busy_q    <= 1'b1;
            end else begin
              state  <= S_FIN;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!LOAD_bar) begin
            state     <= S_IDLE;
            remaining <= '0;
            busy_q    <= 1'b0;
          end else if (step) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state  <= S_FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign display_value = value;
  assign BUS_out       = ASSERT_bar ? {WIDTH{1'bz}} : value;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign WRAP          = wrap_q;

endmodule
